pll_phase_ctl: RTL

- Runtime controller that drives the Gowin PLL primitive's dynamic control inputs.
- Sequences PLL reset and waits for LOCK.
- Accepts phase-shift requests (channel, direction, step count) and turns each into a timed PSSEL/PSDIR/PSPULSE stepping sequence.
- Sits beside the clock-generation PLL wrapper. Lets SDRAM/video clock phase be tuned at runtime, e.g. from an on-screen menu, instead of fixed at build time.

---
 rtl/pll_phase_ctl.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pll_phase_ctl.sv
// Gowin PLL runtime controller: reset/lock sequencing plus timed PSSEL/PSDIR/PSPULSE phase stepping.
// Optional PLL_PHASE_TRACK_EN adds seven per-channel phase position trackers read back through pos_sel/pos.
module pll_phase_ctl #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned PULSE_WIDTH  = 4,
    parameter int unsigned GAP_CYCLES   = 4,
    parameter int unsigned PHASE_STEPS  = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lock,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_sel,
    input  logic       req_dir,
    input  logic [7:0] req_steps,
    output logic       done,
    output logic       err,
    output logic       pll_reset,
    output logic [2:0] pssel,
    output logic       psdir,
    output logic       pspulse,
    output logic       locked,
    input  logic [2:0] pos_sel,
    output logic [7:0] pos
);
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned STEP_W = 8;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned NCH    = 7;

    typedef enum logic [2:0] {
        ST_RST,
        ST_WAITLOCK,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_GAP
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              dir_q, dir_d;
    logic              lock_s1_q, lock_s2_q;
    logic              req_ready_q, req_ready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              pll_reset_q, pll_reset_d;
    logic [SEL_W-1:0]  pssel_q, pssel_d;
    logic              psdir_q, psdir_d;
    logic              pspulse_q, pspulse_d;
    logic              locked_q, locked_d;
    logic              stepping_d;

    // LOCK comes straight from the PLL, so it is resynchronised before use
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_s1_q <= 1'b0;
            lock_s2_q <= 1'b0;
        end else begin
            lock_s1_q <= lock;
            lock_s2_q <= lock_s1_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        sel_d       = sel_q;
        dir_d       = dir_q;
        err_d       = err_q;
        done_d      = 1'b0;
        stepping_d  = 1'b0;
        pll_reset_d = 1'b0;
        req_ready_d = 1'b0;
        pspulse_d   = 1'b0;
        pssel_d     = '0;
        psdir_d     = 1'b0;
        locked_d    = 1'b0;

        case (state_q)
            ST_RST: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_d = ST_WAITLOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAITLOCK: begin
                if (lock_s2_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_d = ST_RST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if (!lock_s2_q) begin
                    // Lock lost: abandon remaining steps and restart the PLL
                    state_d = ST_RST;
                    cnt_d   = '0;
                    rem_d   = '0;
                    if (state_q != ST_IDLE) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (req_valid && req_ready_q) begin
                                err_d = 1'b0;
                                sel_d = req_sel;
                                dir_d = req_dir;
                                rem_d = req_steps;
                                cnt_d = '0;
                                if (req_sel == SEL_W'(NCH)) begin
                                    err_d  = 1'b1;
                                    done_d = 1'b1;
                                end else if (req_steps == '0) begin
                                    done_d = 1'b1;
                                end else begin
                                    state_d = ST_SETUP;
                                end
                            end
                        end
                        ST_SETUP: begin
                            if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
                                state_d = ST_PULSE;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                        ST_PULSE: begin
                            if (cnt_q == CNT_W'(PULSE_WIDTH - 1)) begin
                                state_d = ST_GAP;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                        ST_GAP: begin
                            if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                                cnt_d = '0;
                                rem_d = rem_q - STEP_W'(1);
                                if (rem_q == STEP_W'(1)) begin
                                    state_d = ST_IDLE;
                                    done_d  = 1'b1;
                                end else begin
                                    state_d = ST_PULSE;
                                end
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                        default: state_d = ST_RST;
                    endcase
                end
            end
        endcase

        // Outputs follow the next state so they change on the same edge as the state
        stepping_d  = (state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_GAP);
        pll_reset_d = (state_d == ST_RST);
        req_ready_d = (state_d == ST_IDLE);
        pspulse_d   = (state_d == ST_PULSE);
        pssel_d     = stepping_d ? sel_d : '0;
        psdir_d     = stepping_d && dir_d;
        locked_d    = lock_s2_q && (stepping_d || (state_d == ST_IDLE));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RST;
            cnt_q       <= '0;
            rem_q       <= '0;
            sel_q       <= '0;
            dir_q       <= 1'b0;
            req_ready_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            pll_reset_q <= 1'b1;
            pssel_q     <= '0;
            psdir_q     <= 1'b0;
            pspulse_q   <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            sel_q       <= sel_d;
            dir_q       <= dir_d;
            req_ready_q <= req_ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            pll_reset_q <= pll_reset_d;
            pssel_q     <= pssel_d;
            psdir_q     <= psdir_d;
            pspulse_q   <= pspulse_d;
            locked_q    <= locked_d;
        end
    end

    assign req_ready = req_ready_q;
    assign done      = done_q;
    assign err       = err_q;
    assign pll_reset = pll_reset_q;
    assign pssel     = pssel_q;
    assign psdir     = psdir_q;
    assign pspulse   = pspulse_q;
    assign locked    = locked_q;

`ifdef PLL_PHASE_TRACK_EN
    logic [STEP_W-1:0] trk_q [NCH];
    logic [STEP_W-1:0] trk_d [NCH];
    logic [STEP_W-1:0] pos_q, pos_d;

    // Each pspulse rising edge moves the selected channel one position, wrapping at PHASE_STEPS
    always_comb begin
        trk_d = trk_q;
        pos_d = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (pspulse_d && !pspulse_q && (sel_q == SEL_W'(i))) begin
                if (dir_q) begin
                    trk_d[i] = (trk_q[i] == '0) ? STEP_W'(PHASE_STEPS - 1) : trk_q[i] - STEP_W'(1);
                end else begin
                    trk_d[i] = (trk_q[i] == STEP_W'(PHASE_STEPS - 1)) ? '0 : trk_q[i] + STEP_W'(1);
                end
            end
            if (pos_sel == SEL_W'(i)) begin
                pos_d = trk_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                trk_q[i] <= '0;
            end
            pos_q <= '0;
        end else begin
            trk_q <= trk_d;
            pos_q <= pos_d;
        end
    end

    assign pos = pos_q;
`else
    logic unused_track;
    assign unused_track = ^{pos_sel, STEP_W'(PHASE_STEPS)};
    assign pos          = '0;
`endif

endmodule
